// File: rtl/buffer_reg_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter in front of a single buffer register.
// State encodings, requester count and the pointer-advance helper live here.
package buffer_reg_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam int          NUM_REQ    = 3;
   localparam logic [1:0]  OWNER_NONE = 2'd0;

   // Requester indices run 1..3, so 3 wraps back to 1 (never 0).
   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == 2'd3) ? 2'd1 : i + 2'd1;
   endfunction

endpackage

// File: rtl/buffer_reg_arbiter_buf.sv
// Shared storage: a WIDTH-bit register that captures x when load is high
// and clears synchronously on clr.
module controlled_buffer_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH:1]   x,
   output logic [WIDTH:1]   q
);

   logic [WIDTH:1] q_reg;

   always_ff @(posedge clk) begin
      if (clr)
         q_reg <= '0;
      else if (load)
         q_reg <= x;
   end

   assign q = q_reg;

endmodule

// File: rtl/buffer_reg_arbiter.sv
// Three-requester round-robin arbiter owning one shared buffer register.
// Each transfer is IDLE (arbitrate) -> LOAD (write buffer) -> ACK (one-cycle grant).
module buffer_reg_arbiter
   import buffer_reg_arbiter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [3:1]       req,
   input  logic [WIDTH:1]   d1,
   input  logic [WIDTH:1]   d2,
   input  logic [WIDTH:1]   d3,
   output logic [3:1]       gnt,
   output logic [WIDTH:1]   q,
   output logic [2:1]       owner,
   output logic             busy
);

   state_t         state_reg, state_next;
   logic [2:1]     sel_reg, sel_next;
   logic [2:1]     ptr_reg, ptr_next;
   logic [2:1]     owner_reg, owner_next;
   logic [2:1]     win;
   logic           load;
   logic [WIDTH:1] x;

   // Round-robin scan starting at the pointer: ptr, ptr+1, ptr+2.
   always_comb begin
      logic [1:0] cand;
      logic       found;
      win   = ptr_reg;
      cand  = ptr_reg;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[cand]) begin
            win   = cand;
            found = 1'b1;
         end
         cand = next_idx(cand);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_reg <= IDLE;
         sel_reg   <= 2'd1;
         ptr_reg   <= 2'd1;
         owner_reg <= OWNER_NONE;
      end else begin
         state_reg <= state_next;
         sel_reg   <= sel_next;
         ptr_reg   <= ptr_next;
         owner_reg <= owner_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      sel_next   = sel_reg;
      ptr_next   = ptr_reg;
      owner_next = owner_reg;
      case (state_reg)
         IDLE: begin
            if (req != 3'b000) begin
               sel_next   = win;
               state_next = LOAD;
            end
         end
         LOAD: begin
            // Owner becomes visible in the same cycle the grant is shown.
            owner_next = sel_reg;
            state_next = ACK;
         end
         ACK: begin
            ptr_next   = next_idx(sel_reg);
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      load = (state_reg == LOAD);
      busy = (state_reg != IDLE);
      case (sel_reg)
         2'd1:    x = d1;
         2'd2:    x = d2;
         default: x = d3;
      endcase
   end

   for (genvar gi = 1; gi <= NUM_REQ; gi++) begin : g_gnt
      assign gnt[gi] = (state_reg == ACK) && (sel_reg == gi[1:0]);
   end

   assign owner = owner_reg;

   controlled_buffer_reg #(.WIDTH(WIDTH)) u_buf (
      .clk  (clk),
      .clr  (clr),
      .load (load),
      .x    (x),
      .q    (q)
   );

endmodule

// File: doc/buffer_reg_arbiter.md
BUFFER_REG_ARBITER -- requirements
Module: buffer_reg_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width of each requester and of the shared buffer register.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port clr  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  [3:1]  per-requester write request, bit i = requester i.
REQ-005 SHALL have port d1, d2, d3  input  [WIDTH:1] each  write data of requesters 1..3.
REQ-006 SHALL have port gnt  output  [3:1]  one-hot, one-cycle grant/ack to the requester whose data was written.
REQ-007 SHALL have port q  output  [WIDTH:1]  contents of the shared buffer register.
REQ-008 SHALL have port owner  output  [2:1]  index (1..3) of the last writer; 0 = none since reset.
REQ-009 SHALL have port busy  output  1  high while a transfer is in progress (state LOAD or ACK).

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, ACK.
REQ-011 IDLE, req==0: SHALL remain in IDLE with gnt=0.
REQ-012 IDLE, req!=0: SHALL pick the winner round-robin, starting at pointer ptr and scanning ptr, ptr+1, ptr+2 (mod 3, values 1..3); SHALL register the winner in sel; SHALL go to LOAD.
REQ-013 LOAD: SHALL drive buffer load=1 with x = d[sel]; q SHALL take d[sel] at the closing edge; SHALL go to ACK.
REQ-014 ACK: SHALL assert gnt[sel]=1 for exactly this cycle and show owner=sel; SHALL set ptr=sel+1 (3 wraps to 1); SHALL return to IDLE.
REQ-015 Latency: req sampled at edge k -> q updated at edge k+1 -> gnt high during cycle k+1..k+2.
REQ-016 Throughput: at most one transfer per 3 cycles.
REQ-017 Requesters SHALL hold req and data stable until gnt; requesters SHALL drop req in the cycle after gnt, or keep it to request again.
REQ-018 Outside LOAD, buffer load SHALL be 0 and q SHALL hold its value.
REQ-019 req changes during LOAD/ACK SHALL be ignored; the transfer in flight SHALL complete using data sampled in LOAD.
REQ-020 Simultaneous requests SHALL be served in round-robin order: no requester waits more than 2 other grants.
REQ-021 gnt SHALL be zero or one-hot at all times.
REQ-022 busy SHALL equal (state != IDLE).

Reset
REQ-023 clr=1 at an edge SHALL force state=IDLE, ptr=1, sel=1, gnt=0, owner=0, busy=0, q=0, irrespective of state.
REQ-024 clr during LOAD or ACK SHALL abort the transfer: no gnt is issued and q SHALL read 0 afterwards.
REQ-025 clr SHALL take priority over req at the same edge.

Structure
REQ-026 The shared package SHALL hold state encodings (IDLE=2'd0, LOAD=2'd1, ACK=2'd2), NUM_REQ=3, OWNER_NONE=2'd0.
REQ-027 SHALL instantiate one sub-module controlled_buffer_reg (clk, clr, load, x, q) as the shared storage; arbitration and FSM logic SHALL stay in buffer_reg_arbiter.

Verification
REQ-028 Reset: hold clr=1 for 2 cycles with req=3'b111 -> gnt=0, q=0, owner=0, busy=0 throughout.
REQ-029 Single request: req=3'b010, d2=4'b1010 -> q=1010 one edge after sampling; gnt=3'b010 for one cycle; owner=2; busy high for 2 cycles.
REQ-030 Contention: req=3'b111 held with d1=0001, d2=0010, d3=0100 -> grants in order 001, 010, 100, 001; q sequence 0001, 0010, 0100.
REQ-031 Pointer wrap: grant requester 3, then req=3'b101 -> requester 1 is granted before requester 3.
REQ-032 Reset mid-transfer: assert clr in LOAD cycle -> no gnt, q=0, state IDLE next cycle.
REQ-033 Idle hold: req=0 for 10 cycles after a write of 1111 -> q stays 1111, gnt=0, busy=0.
